// File: rtl/fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_pkg
// Description : Shared types and constants for the FIFO burst-drain consumer.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_drain_pkg;

  // Drain controller states: waiting for enough data, or popping a burst.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } drain_state_t;

  // Entries in the output skid buffer.
  localparam int SKID_DEPTH = 2;

endpackage : fifo_drain_pkg
`default_nettype wire

// File: rtl/drain_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : drain_skid_buf
// Description : 2-entry {data,last} skid buffer between the FIFO pop side and
//               the valid/ready output stream. Head entry drives the stream.
// Revision    : 1.0 - initial release
// ============================================================================
module drain_skid_buf
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic [1:0]            count_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_last_o
);

  logic [DATA_WIDTH-1:0] data_q [SKID_DEPTH];
  logic                  last_q [SKID_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic                  push_ok;
  logic                  pop_ok;

  // Guard against writing a full buffer or reading an empty one.
  assign push_ok = push_i && (count_q != 2'(SKID_DEPTH));
  assign pop_ok  = pop_i && (count_q != 2'd0);

  // Occupancy update; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count; reset discards any buffered words.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        data_q[wr_ptr_q] <= push_data_i;
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign head_data_o = data_q[rd_ptr_q];
  assign head_last_o = last_q[rd_ptr_q];

endmodule : drain_skid_buf
`default_nettype wire

// File: rtl/fifo_burst_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_drain
// Description : Pops fixed-length bursts from an upstream synchronous FIFO
//               and presents them on a valid/ready stream with m_last on the
//               final word of each burst. A 2-entry skid buffer keeps the pop
//               path free of any combinational dependence on m_ready.
//               Optional: define FIFO_DRAIN_TIMEOUT_EN to flush a partial
//               burst after TIMEOUT idle cycles with data waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH+1:0] fifo_level,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int LW = ADDR_WIDTH + 2;
  localparam int RW = $clog2(BURST_LEN + 1);
  localparam logic [LW-1:0] C_BURST_LVL = LW'(BURST_LEN);

  if (BURST_LEN < 1 || BURST_LEN > FIFO_DEPTH) begin : g_chk_burst_len
    $error("BURST_LEN must lie in 1..FIFO_DEPTH");
  end
  if (TIMEOUT < 1) begin : g_chk_timeout
    $error("TIMEOUT must be at least 1");
  end

  drain_state_t  state_q, state_d;
  logic [RW-1:0] remaining_q, remaining_d;
  logic [1:0]    skid_count;
  logic          skid_pop;

`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_timer_q, idle_timer_d;
`endif

  // Next-state, burst counter, idle timer and FIFO pop request.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    fifo_rd_en   = 1'b0;
`ifdef FIFO_DRAIN_TIMEOUT_EN
    idle_timer_d = idle_timer_q;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_level >= C_BURST_LVL) begin
          state_d      = BURST;
          remaining_d  = RW'(BURST_LEN);
`ifdef FIFO_DRAIN_TIMEOUT_EN
          idle_timer_d = '0;
        end else if (fifo_level == '0) begin
          idle_timer_d = '0;
        end else if (idle_timer_q == TW'(TIMEOUT - 1)) begin
          // Partial flush: level is below BURST_LEN so it fits in remaining.
          state_d      = BURST;
          remaining_d  = RW'(fifo_level);
          idle_timer_d = '0;
        end else if (idle_timer_q != TW'(TIMEOUT)) begin
          idle_timer_d = idle_timer_q + TW'(1);
`endif
        end
      end
      BURST: begin
        // Registered skid count gates the pop, so the skid can never overflow.
        fifo_rd_en = !fifo_empty && (skid_count < 2'(SKID_DEPTH));
`ifdef FIFO_DRAIN_TIMEOUT_EN
        idle_timer_d = '0;
`endif
        if (fifo_rd_en) begin
          remaining_d = remaining_q - RW'(1);
          if (remaining_q == RW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, burst counter and idle timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
`ifdef FIFO_DRAIN_TIMEOUT_EN
      idle_timer_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
`ifdef FIFO_DRAIN_TIMEOUT_EN
      idle_timer_q <= idle_timer_d;
`endif
    end
  end

  assign skid_pop = m_valid && m_ready;

  drain_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_rd_en),
    .push_data_i (fifo_dout),
    .push_last_i (remaining_q == RW'(1)),
    .pop_i       (skid_pop),
    .count_o     (skid_count),
    .head_data_o (m_data),
    .head_last_o (m_last)
  );

  assign m_valid = (skid_count != 2'd0);
  assign busy    = (state_q != IDLE) || (skid_count != 2'd0);

endmodule : fifo_burst_drain
`default_nettype wire

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
- Read-side consumer placed directly downstream of the team's synchronous FIFO.
- Watches the FIFO fill level, pops words in fixed-length bursts, and presents them on a valid/ready stream with a last-word marker.
- A 2-entry skid buffer decouples FIFO pops from downstream backpressure, so a pop never blocks on m_ready combinationally.

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO.
- ADDR_WIDTH, 4, FIFO address width; sets the fifo_level width.
- FIFO_DEPTH, 16, FIFO capacity in words.
- BURST_LEN, 4, words per full burst; legal range 1..FIFO_DEPTH.
- TIMEOUT, 16, idle cycles before a partial burst is flushed; must be >= 1. Used only with FIFO_DRAIN_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO holds no readable word.
- fifo_level  in  ADDR_WIDTH+2  FIFO occupancy in words.
- fifo_dout  in  DATA_WIDTH  head word; valid when fifo_empty=0.
- fifo_rd_en  out  1  pop request; the head word is consumed at this edge.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  DATA_WIDTH  stream word.
- m_last  out  1  final word of the burst.
- busy  out  1  burst in progress or skid buffer not empty.

Behaviour:
- Reset:
  - state=IDLE; remaining=0; idle_timer=0; skid count=0.
  - fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0.
  - Reset mid-burst discards skid contents; the popped words are lost by design.
- FSM state IDLE:
  - If fifo_level >= BURST_LEN: latch remaining=BURST_LEN and go to BURST.
  - Else, with the timeout feature enabled, see Optional Feature.
  - fifo_rd_en=0 in IDLE.
- FSM state BURST:
  - fifo_rd_en = !fifo_empty && skid_count<2, combinational from registered state.
  - Each pop writes {fifo_dout, remaining==1} into the skid at the same edge and decrements remaining.
  - On the pop with remaining==1, go to IDLE. There is always one IDLE cycle between bursts.
  - fifo_empty=1 during BURST stalls the pop only; no error, stay in BURST.
- Latency: if fifo_level>=BURST_LEN is first sampled in cycle c:
  - fifo_rd_en goes high in c+1;
  - m_valid goes high in c+2 with the first word.
- Throughput: with m_ready held high, one word per cycle during a burst; skid count holds at 1 (push and pop on the same edge).
- Skid buffer:
  - 2-entry FIFO of {data, last}; m_valid = count!=0; m_data/m_last come from the head entry.
  - Pop on m_valid && m_ready. A simultaneous push and pop keeps count unchanged.
  - While m_valid && !m_ready, m_data and m_last stay stable.
  - Count never exceeds 2: the pop gate uses registered count, so no overflow is possible.
- Ordering: words leave in FIFO order. A new burst may start while the previous burst's last word is still in the skid.
- busy = state!=IDLE || skid_count!=0.
- Widths:
  - remaining is $clog2(BURST_LEN+1) bits.
  - idle_timer is $clog2(TIMEOUT+1) bits and saturates at TIMEOUT.
  - Level comparisons are unsigned at ADDR_WIDTH+2 bits.

Optional Feature:
- Macro FIFO_DRAIN_TIMEOUT_EN.
- Defined:
  - In IDLE with 0 < fifo_level < BURST_LEN, idle_timer increments every cycle.
  - idle_timer clears when fifo_level==0, when a full burst starts, or on leaving IDLE.
  - When idle_timer==TIMEOUT-1, latch remaining=fifo_level and go to BURST. This partial burst ends with m_last on its final word.
- Undefined:
  - No idle_timer; only full BURST_LEN bursts are ever issued.
  - Fewer than BURST_LEN words remain in the FIFO indefinitely.

Decomposition:
- Package fifo_drain_pkg:
  - typedef enum logic {IDLE, BURST} drain_state_t;
  - constant SKID_DEPTH=2.
- One sub-module, drain_skid_buf, parameterised by DATA_WIDTH:
  - 2-entry {data,last} buffer with push, pop, count, head outputs.
  - The top level holds the FSM, the remaining counter and the timer.

Test Plan:
- BURST_LEN=4, FIFO pre-filled with 0x11..0x14, m_ready=1 -> fifo_rd_en high 4 consecutive cycles starting 1 cycle after level sampled; m_data 0x11,0x12,0x13,0x14 on consecutive cycles; m_last only on 0x14; busy drops after last handshake.
- 8 words 0xA0..0xA7 -> two bursts; m_last on 0xA3 and 0xA7; exactly one IDLE cycle between last pop of burst 1 and first pop of burst 2.
- Backpressure: m_ready=0 for 5 cycles mid-burst -> skid fills to 2, fifo_rd_en=0; m_data held stable; no word lost or duplicated after m_ready=1.
- FIFO_DRAIN_TIMEOUT_EN, TIMEOUT=16, 3 words 0x01..0x03 -> burst starts after 16 IDLE cycles; 3 words output, m_last on 0x03. Without the macro -> no fifo_rd_en, level stays 3.
- Reset asserted while 2 words sit in skid mid-burst -> next cycle m_valid=0, fifo_rd_en=0, busy=0, state IDLE; refill 4 words -> normal burst resumes.
- BURST_LEN=1 -> every word emitted with m_last=1.
